fp_add_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point adder. Successor to the combinational BF16/FP32 adders.
- One generic datapath covers BF16 (EXP_W=8, MAN_W=7) and FP32 (EXP_W=8, MAN_W=23).
- Three-stage pipeline with round-to-nearest-even, exception flags and valid/ready handshake on both sides.
- Sits between the matmul accumulator and the result writeback path; accepts one operand pair per cycle.

---
 rtl/fp_add_pipe_if.sv | 43 ++++
 rtl/fp_add_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pipe_if.sv
// Valid/ready handshake bundle for fp_add_pipe (operand side and result side).
// The op_sub signal exists only when FP_ADD_SUB_EN is defined.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
`ifdef FP_ADD_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

`ifdef FP_ADD_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_tag, op_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_tag, out_flags
  );
  modport slave (
    input  in_valid, in_a, in_b, in_tag, op_sub, out_ready,
    output in_ready, out_valid, out_sum, out_tag, out_flags
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag, out_flags
  );
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag, out_flags
  );
`endif
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder (unpack/align, add/sub, normalise/round).
// Optional macro FP_ADD_SUB_EN adds op_sub, which negates operand B to compute A-B.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  fp_add_pipe_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int LZ_W  = $clog2(SIG_W + 1);
  localparam int XE_W  = EXP_W + 2;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XE_W-1:0]  XE_ZERO  = '0;
  localparam logic signed [XE_W-1:0]  EXP_MAX  = {2'b00, EXP_ONES};

  logic adv;

  logic v1_q, v1_d, spec1_q, spec1_d, sign1_q, sign1_d, sub1_q, sub1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [W-1:0]     sres1_q, sres1_d;
  logic [3:0]       sfl1_q, sfl1_d;
  logic [EXP_W-1:0] exp1_q, exp1_d;
  logic [SIG_W-1:0] sigl1_q, sigl1_d, sigs1_q, sigs1_d;

  logic v2_q, v2_d, spec2_q, spec2_d, sign2_q, sign2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic [W-1:0]     sres2_q, sres2_d;
  logic [3:0]       sfl2_q, sfl2_d;
  logic [EXP_W-1:0] exp2_q, exp2_d;
  logic [SIG_W:0]   sum2_q, sum2_d;

  logic v3_q, v3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  logic [W-1:0]     res3_q, res3_d;
  logic [3:0]       fl3_q, fl3_d;

  assign adv           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.out_sum   = res3_q;
  assign bus.out_tag   = tag3_q;
  assign bus.out_flags = fl3_q;

  // ---------------- stage 1: unpack, classify, swap, align
  logic [W-1:0]     b_eff;
  logic             sa, sb, za, zb, ia, ib, na, nb, swap, sl, zs;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic [W-2:0]     mag_a, mag_b;
  logic [SIG_W-1:0] ext_s, shifted, lost, sig_s_al;
  logic             spec_c;
  logic [W-1:0]     spec_res_c;
  logic [3:0]       spec_fl_c;

`ifdef FP_ADD_SUB_EN
  assign b_eff = {bus.in_b[W-1] ^ bus.op_sub, bus.in_b[W-2:0]};
`else
  assign b_eff = bus.in_b;
`endif

  assign {sa, ea, fa} = bus.in_a;
  assign {sb, eb, fb} = b_eff;
  assign za    = (ea == '0);
  assign zb    = (eb == '0);
  assign ia    = (ea == EXP_ONES) && (fa == '0);
  assign ib    = (eb == EXP_ONES) && (fb == '0);
  assign na    = (ea == EXP_ONES) && (fa != '0);
  assign nb    = (eb == EXP_ONES) && (fb != '0);
  // subnormals compare as zero magnitude since they are flushed
  assign mag_a = za ? '0 : bus.in_a[W-2:0];
  assign mag_b = zb ? '0 : b_eff[W-2:0];
  assign swap  = (mag_b > mag_a);
  assign sl    = swap ? sb : sa;
  assign el    = swap ? eb : ea;
  assign fl    = swap ? fb : fa;
  assign es    = swap ? ea : eb;
  assign fs    = swap ? fa : fb;
  assign zs    = swap ? za : zb;
  assign d     = el - es;

  always_comb begin
    ext_s    = {~zs, fs, 3'b000};
    shifted  = '0;
    lost     = '0;
    sig_s_al = '0;
    if (d >= EXP_W'(MAN_W + 3)) begin
      sig_s_al = {{(SIG_W-1){1'b0}}, ~zs};
    end else begin
      shifted  = ext_s >> d;
      lost     = ext_s & ~({SIG_W{1'b1}} << d);
      sig_s_al = {shifted[SIG_W-1:1], shifted[0] | (|lost)};
    end
  end

  always_comb begin
    spec_c     = 1'b1;
    spec_res_c = '0;
    spec_fl_c  = 4'b0000;
    if (na || nb || (ia && ib && (sa != sb))) begin
      spec_res_c = QNAN;
      spec_fl_c  = 4'b1000;
    end else if (ia) begin
      spec_res_c = bus.in_a;
    end else if (ib) begin
      spec_res_c = b_eff;
    end else if (za && zb) begin
      spec_res_c = {sa & sb, {(W-1){1'b0}}};
    end else if (za) begin
      spec_res_c = b_eff;
    end else if (zb) begin
      spec_res_c = bus.in_a;
    end else begin
      spec_c = 1'b0;
    end
  end

  // ---------------- stage 3: normalise, round, pack
  logic [LZ_W-1:0]         lzc;
  logic [SIG_W-1:0]        norm;
  logic signed [XE_W-1:0]  exp_n, exp_r;
  logic                    g, r, s, inc;
  logic [MAN_W+1:0]        mant;
  logic [MAN_W-1:0]        frac_r;
  logic [W-1:0]            res_c;
  logic [3:0]              fl_c;

  always_comb begin
    lzc = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (sum2_q[i]) lzc = LZ_W'(SIG_W - 1 - i);
    end
    if (sum2_q[SIG_W]) begin
      norm  = {sum2_q[SIG_W:2], sum2_q[1] | sum2_q[0]};
      exp_n = {2'b00, exp2_q} + XE_W'(1);
    end else begin
      norm  = sum2_q[SIG_W-1:0] << lzc;
      exp_n = {2'b00, exp2_q} - XE_W'(lzc);
    end
    g    = norm[2];
    r    = norm[1];
    s    = norm[0];
    inc  = g & (r | s | norm[3]);
    mant = {1'b0, norm[SIG_W-1:3]} + (MAN_W+2)'(inc);
    if (mant[MAN_W+1]) begin
      frac_r = mant[MAN_W:1];
      exp_r  = exp_n + XE_W'(1);
    end else begin
      frac_r = mant[MAN_W-1:0];
      exp_r  = exp_n;
    end

    res_c = '0;
    fl_c  = 4'b0000;
    if (spec2_q) begin
      res_c = sres2_q;
      fl_c  = sfl2_q;
    end else if (sum2_q == '0) begin
      res_c = '0;
    end else if (exp_n <= XE_ZERO) begin
      res_c = {sign2_q, {(W-1){1'b0}}};
      fl_c  = 4'b0011;
    end else if (exp_r >= EXP_MAX) begin
      res_c = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      fl_c  = 4'b0101;
    end else begin
      res_c = {sign2_q, exp_r[EXP_W-1:0], frac_r};
      fl_c  = {3'b000, g | r | s};
    end
  end

  // ---------------- pipeline register next-state; every stage holds when !adv
  always_comb begin
    v1_d = v1_q;  tag1_d = tag1_q;  spec1_d = spec1_q;  sres1_d = sres1_q;
    sfl1_d = sfl1_q;  sign1_d = sign1_q;  sub1_d = sub1_q;  exp1_d = exp1_q;
    sigl1_d = sigl1_q;  sigs1_d = sigs1_q;
    v2_d = v2_q;  tag2_d = tag2_q;  spec2_d = spec2_q;  sres2_d = sres2_q;
    sfl2_d = sfl2_q;  sign2_d = sign2_q;  exp2_d = exp2_q;  sum2_d = sum2_q;
    v3_d = v3_q;  tag3_d = tag3_q;  res3_d = res3_q;  fl3_d = fl3_q;
    if (adv) begin
      v1_d    = bus.in_valid;
      tag1_d  = bus.in_tag;
      spec1_d = spec_c;
      sres1_d = spec_res_c;
      sfl1_d  = spec_fl_c;
      sign1_d = sl;
      sub1_d  = sa ^ sb;
      exp1_d  = el;
      sigl1_d = {1'b1, fl, 3'b000};
      sigs1_d = sig_s_al;

      v2_d    = v1_q;
      tag2_d  = tag1_q;
      spec2_d = spec1_q;
      sres2_d = sres1_q;
      sfl2_d  = sfl1_q;
      sign2_d = sign1_q;
      exp2_d  = exp1_q;
      sum2_d  = sub1_q ? ({1'b0, sigl1_q} - {1'b0, sigs1_q})
                       : ({1'b0, sigl1_q} + {1'b0, sigs1_q});

      v3_d    = v2_q;
      tag3_d  = tag2_q;
      res3_d  = res_c;
      fl3_d   = fl_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;  tag1_q <= '0;  spec1_q <= 1'b0;  sres1_q <= '0;  sfl1_q <= '0;
      sign1_q <= 1'b0;  sub1_q <= 1'b0;  exp1_q <= '0;  sigl1_q <= '0;  sigs1_q <= '0;
      v2_q <= 1'b0;  tag2_q <= '0;  spec2_q <= 1'b0;  sres2_q <= '0;  sfl2_q <= '0;
      sign2_q <= 1'b0;  exp2_q <= '0;  sum2_q <= '0;
      v3_q <= 1'b0;  tag3_q <= '0;  res3_q <= '0;  fl3_q <= '0;
    end else begin
      v1_q <= v1_d;  tag1_q <= tag1_d;  spec1_q <= spec1_d;  sres1_q <= sres1_d;  sfl1_q <= sfl1_d;
      sign1_q <= sign1_d;  sub1_q <= sub1_d;  exp1_q <= exp1_d;  sigl1_q <= sigl1_d;  sigs1_q <= sigs1_d;
      v2_q <= v2_d;  tag2_q <= tag2_d;  spec2_q <= spec2_d;  sres2_q <= sres2_d;  sfl2_q <= sfl2_d;
      sign2_q <= sign2_d;  exp2_q <= exp2_d;  sum2_q <= sum2_d;
      v3_q <= v3_d;  tag3_q <= tag3_d;  res3_q <= res3_d;  fl3_q <= fl3_d;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: BF16 and FP32 instances sharing clock and reset.
module tb_fp_add_pipe;
  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  logic sub16       = 1'b0;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(7),  .TAG_W(4)) if16 ();
  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) if32 ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(7),  .TAG_W(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one BF16 pair, then count rising edges (transfer edge included) until out_valid.
  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                         output logic [15:0] sum, output logic [3:0] flags,
                         output logic [3:0] tag_o, output int lat);
    @(negedge clk);
    if16.in_valid  = 1'b1;
    if16.in_a      = a;
    if16.in_b      = b;
    if16.in_tag    = tag;
    if16.out_ready = 1'b1;
`ifdef FP_ADD_SUB_EN
    if16.op_sub    = sub16;
`endif
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if16.in_valid = 1'b0;
    while (!if16.out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    sum   = if16.out_sum;
    flags = if16.out_flags;
    tag_o = if16.out_tag;
  endtask

  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         output logic [31:0] sum, output logic [3:0] flags,
                         output logic [3:0] tag_o, output int lat);
    @(negedge clk);
    if32.in_valid  = 1'b1;
    if32.in_a      = a;
    if32.in_b      = b;
    if32.in_tag    = tag;
    if32.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if32.in_valid = 1'b0;
    while (!if32.out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    sum   = if32.out_sum;
    flags = if32.out_flags;
    tag_o = if32.out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_tag = '0; if16.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_tag = '0; if32.out_ready = 1'b1;
`ifdef FP_ADD_SUB_EN
    if16.op_sub = 1'b0;
    if32.op_sub = 1'b0;
`endif
    #2 rst = 1'b0;
    #1;
    vectors++; if (if16.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", if16.out_valid); end
    vectors++; if (if16.out_sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum: got %h expected 0000", if16.out_sum); end
    vectors++; if (if16.out_tag !== 4'h0 || if16.out_flags !== 4'h0) begin miscompares++; $display("FAIL reset_tag_flags: got %h/%h expected 0/0", if16.out_tag, if16.out_flags); end
    vectors++; if (if32.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid32: got %b expected 0", if32.out_valid); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_round();
    logic [15:0] s; logic [3:0] f; logic [3:0] t; int lat;
    do_op16(16'h3F80, 16'h3F80, 4'h1, s, f, t, lat);
    vectors++; if (s !== 16'h4000) begin miscompares++; $display("FAIL one_plus_one sum: got %h expected 4000", s); end
    vectors++; if (f !== 4'h0) begin miscompares++; $display("FAIL one_plus_one flags: got %b expected 0000", f); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL one_plus_one latency: got %0d expected 3", lat); end
    vectors++; if (t !== 4'h1) begin miscompares++; $display("FAIL one_plus_one tag: got %h expected 1", t); end
    do_op16(16'h3F80, 16'hBF80, 4'h2, s, f, t, lat);
    vectors++; if (s !== 16'h0000 || f !== 4'h0) begin miscompares++; $display("FAIL cancel: got %h/%b expected 0000/0000", s, f); end
    do_op16(16'h3F80, 16'h3B80, 4'h3, s, f, t, lat);
    vectors++; if (s !== 16'h3F80 || f !== 4'b0001) begin miscompares++; $display("FAIL tie_even: got %h/%b expected 3f80/0001", s, f); end
    do_op16(16'h3F81, 16'h3B80, 4'h4, s, f, t, lat);
    vectors++; if (s !== 16'h3F82 || f !== 4'b0001) begin miscompares++; $display("FAIL tie_up: got %h/%b expected 3f82/0001", s, f); end
    do_op16(16'h3F80, 16'h4000, 4'h5, s, f, t, lat);
    vectors++; if (s !== 16'h4040 || f !== 4'h0) begin miscompares++; $display("FAIL swap_add: got %h/%b expected 4040/0000", s, f); end
  endtask

  task automatic test_specials();
    logic [15:0] s; logic [3:0] f; logic [3:0] t; int lat;
    do_op16(16'h7F80, 16'hFF80, 4'h6, s, f, t, lat);
    vectors++; if (s !== 16'h7FC0 || f !== 4'b1000) begin miscompares++; $display("FAIL inf_minus_inf: got %h/%b expected 7fc0/1000", s, f); end
    do_op16(16'h7F7F, 16'h7F7F, 4'h7, s, f, t, lat);
    vectors++; if (s !== 16'h7F80 || f !== 4'b0101) begin miscompares++; $display("FAIL overflow: got %h/%b expected 7f80/0101", s, f); end
    do_op16(16'h7F81, 16'h3F80, 4'h8, s, f, t, lat);
    vectors++; if (s !== 16'h7FC0 || f !== 4'b1000) begin miscompares++; $display("FAIL nan_in: got %h/%b expected 7fc0/1000", s, f); end
    do_op16(16'hFF80, 16'h3F80, 4'h9, s, f, t, lat);
    vectors++; if (s !== 16'hFF80 || f !== 4'b0000) begin miscompares++; $display("FAIL neg_inf: got %h/%b expected ff80/0000", s, f); end
    do_op16(16'h8000, 16'h8000, 4'hA, s, f, t, lat);
    vectors++; if (s !== 16'h8000 || f !== 4'b0000) begin miscompares++; $display("FAIL neg_zeros: got %h/%b expected 8000/0000", s, f); end
    do_op16(16'h0000, 16'hC040, 4'hB, s, f, t, lat);
    vectors++; if (s !== 16'hC040 || f !== 4'b0000) begin miscompares++; $display("FAIL zero_plus_x: got %h/%b expected c040/0000", s, f); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b_tab [8] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080,
                               16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};
    logic [15:0] s_tab [8] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                               16'h40C0, 16'h40E0, 16'h4100, 16'h4110};
    logic        pat [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    logic in_x, out_x;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      if16.out_ready = pat[cyc % 4];
      if16.in_valid  = (sent < 8);
      if (sent < 8) begin
        if16.in_a   = 16'h3F80;
        if16.in_b   = b_tab[sent];
        if16.in_tag = sent[3:0];
      end
      #1;
      vectors++;
      if (if16.in_ready !== (if16.out_ready | ~if16.out_valid)) begin
        miscompares++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, if16.in_ready, if16.out_ready | ~if16.out_valid);
      end
      if (if16.out_valid) begin
        vectors++;
        if (if16.out_tag !== got[3:0] || if16.out_sum !== s_tab[got]) begin
          miscompares++; $display("FAIL b2b_result cyc %0d: got tag %h sum %h expected tag %h sum %h", cyc, if16.out_tag, if16.out_sum, got[3:0], s_tab[got]);
        end
      end
      in_x  = if16.in_valid & if16.in_ready;
      out_x = if16.out_valid & if16.out_ready;
      @(posedge clk);
      if (in_x)  sent++;
      if (out_x) got++;
      cyc++;
    end
    vectors++; if (got !== 8 || sent !== 8) begin miscompares++; $display("FAIL b2b_count: got %0d results/%0d sent expected 8/8", got, sent); end
    @(negedge clk);
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (if16.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got out_valid %b expected 0", if16.out_valid); end
  endtask

  task automatic test_async_reset();
    logic [15:0] s;  logic [3:0] f; logic [3:0] t; int lat;
    logic [31:0] s32;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if16.in_valid = 1'b1; if16.in_a = 16'h3F80; if16.in_b = 16'h3F80; if16.in_tag = 4'(i + 1); if16.out_ready = 1'b1;
      if32.in_valid = 1'b1; if32.in_a = 32'h3F800000; if32.in_b = 32'h3F800000; if32.in_tag = 4'(i + 1); if32.out_ready = 1'b1;
    end
    @(negedge clk);
    if16.in_valid = 1'b0; if16.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.out_ready = 1'b0;
    vectors++; if (if16.out_valid !== 1'b1) begin miscompares++; $display("FAIL inflight_valid: got %b expected 1", if16.out_valid); end
    #1 rst = 1'b0;
    #1;
    vectors++; if (if16.out_valid !== 1'b0 || if16.out_sum !== 16'h0000) begin miscompares++; $display("FAIL async_rst16: got %b/%h expected 0/0000", if16.out_valid, if16.out_sum); end
    vectors++; if (if32.out_valid !== 1'b0 || if32.out_tag !== 4'h0) begin miscompares++; $display("FAIL async_rst32: got %b/%h expected 0/0", if32.out_valid, if32.out_tag); end
    @(negedge clk);
    rst = 1'b1;
    do_op16(16'h3F80, 16'h3F80, 4'hC, s, f, t, lat);
    vectors++; if (lat !== 3 || t !== 4'hC || s !== 16'h4000) begin miscompares++; $display("FAIL post_rst16: got lat %0d tag %h sum %h expected 3/c/4000", lat, t, s); end
    do_op32(32'h3F800000, 32'h40000000, 4'hD, s32, f, t, lat);
    vectors++; if (s32 !== 32'h40400000 || f !== 4'h0) begin miscompares++; $display("FAIL fp32_sum: got %h/%b expected 40400000/0000", s32, f); end
    vectors++; if (lat !== 3 || t !== 4'hD) begin miscompares++; $display("FAIL fp32_latency_tag: got %0d/%h expected 3/d", lat, t); end
  endtask

`ifdef FP_ADD_SUB_EN
  task automatic test_sub();
    logic [15:0] s; logic [3:0] f; logic [3:0] t; int lat;
    sub16 = 1'b1;
    do_op16(16'h3F80, 16'h3F80, 4'hE, s, f, t, lat);
    vectors++; if (s !== 16'h0000 || f !== 4'h0) begin miscompares++; $display("FAIL sub_cancel: got %h/%b expected 0000/0000", s, f); end
    do_op16(16'h7F80, 16'h7F80, 4'hF, s, f, t, lat);
    vectors++; if (s !== 16'h7FC0 || f !== 4'b1000) begin miscompares++; $display("FAIL sub_inf_inf: got %h/%b expected 7fc0/1000", s, f); end
    sub16 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add_round();
    test_specials();
    test_back_to_back();
    test_async_reset();
`ifdef FP_ADD_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
